pdes_dispatch: RTL
==================

# pdes_dispatch

Parametrised event dispatcher and GVT tracker for the PHOLD engine. It sits between an external priority event queue and `NUM_CORE` PHOLD cores. It seeds the initial events, moves new events from the cores into the queue, dispatches the earliest event to an idle core, and maintains a monotonic global virtual time. It stops when GVT passes a run-time end time or the simulation starves.

## Interface
Parameters:
- `NUM_CORE`, 4: number of cores (≥2).
- `TIME_WID`, 16: timestamp width.
- `LP_WID`, 3: LP id width.
- `NUM_LP`, 4: initial events seeded, one per LP 0..NUM_LP-1 (≤2^LP_WID).
- `MSG_WID`, LP_WID+TIME_WID: event message width, packed `{lp, time}`.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: begin a run; sampled in IDLE only.
- `end_time` in TIME_WID: run ends when gvt > end_time; sampled at start.
- `done` out 1: one-cycle pulse at end of run.
- `starved` out 1: sticky; set when the run ended by starvation; cleared on start.
- `gvt` out TIME_WID: registered global virtual time.
- `disp_cnt` out 32: events dispatched this run; saturating.
- `q_enq` out 1: queue enqueue strobe.
- `q_enq_data` out MSG_WID: enqueue message.
- `q_deq` out 1: queue dequeue strobe.
- `q_head` in MSG_WID: queue head, valid when !q_empty.
- `q_empty` in 1: queue empty.
- `q_full` in 1: queue full.
- `core_ready` in NUM_CORE: core idle and able to accept an event.
- `core_evt_vld` out NUM_CORE: one-hot dispatch strobe.
- `core_evt_data` out MSG_WID: dispatched message (= q_head), broadcast to all cores.
- `core_new_vld` in NUM_CORE: core holds a new event.
- `core_new_data` in NUM_CORE*MSG_WID: per-core new event; core i occupies bits [i*MSG_WID +: MSG_WID].
- `core_new_ack` out NUM_CORE: one-hot accept strobe.

## Operation
States are IDLE, INIT, RUN and DONE.

- **IDLE**
  - On `start`: latch end_time, clear gvt, busy, starved and disp_cnt, load seed index 0, and go to INIT.
- **INIT**
  - Each cycle with !q_full: q_enq=1, q_enq_data={seed_idx, 0}, seed_idx++.
  - After NUM_LP enqueues, go to RUN.
  - With q_full asserted, stall without enqueueing.
- **RUN** — each cycle, in priority order:
  1. Receive: if any core_new_vld and !q_full, the rr receive arbiter picks core k. Assert q_enq, set q_enq_data = core k data, core_new_ack[k]=1, and clear busy[k].
  2. Otherwise dispatch: if !q_empty and any (core_ready & ~busy), the rr send arbiter picks core j. Assert q_deq and core_evt_vld[j], set busy[j], core_time[j]=q_head.time, and increment disp_cnt.
  - Enqueue and dequeue never occur in the same cycle.
  - Each arbiter's pointer advances past the granted core only on its grant.
- **GVT**
  - c_gvt = min over busy cores of core_time and over q_head.time (if !q_empty).
  - gvt register updates only in RUN, and only when at least one term is valid and c_gvt ≥ gvt; otherwise it holds. gvt is monotonic.
- **Termination** (checked in RUN):
  - gvt > end_time_latched: go to DONE.
  - q_empty, busy==0, and core_new_vld==0: set starved=1 and go to DONE.
- **DONE**
  - done=1 for one cycle, then go to IDLE. gvt and disp_cnt hold until the next start.
- **Arithmetic**
  - All time compares are unsigned. There is no wrap handling; timestamps beyond 2^TIME_WID−1 are out of scope.

## Timing
- Reset values: state IDLE; done, starved, q_enq, q_deq, core_evt_vld and core_new_ack all 0; gvt 0; disp_cnt 0; busy 0; arbiter pointers favour core 0.
- q_enq, q_deq, core_evt_vld and core_new_ack are combinational from registered state plus same-cycle inputs. The queue and cores consume them at the same clock edge.
- gvt lags the event that changed it by exactly one cycle.
- done is asserted the cycle after the terminating condition is seen.
- Reset asserted mid-run aborts immediately to the reset values; no done pulse is produced.

## Structure
- Package `pdes_pkg` holds:
  - the state enum;
  - the `{lp, time}` message layout;
  - default TIME_WID / LP_WID constants, shared with phold_core and prio_q.
- Sub-module `rr_arb #(N)`, instantiated twice (receive and send):
  - inputs: req[N], adv;
  - outputs: one-hot gnt[N], any, and binary idx;
  - pointer register advances on adv.
- The GVT min-reduction is a generate-loop tree kept inline.

## Test plan
- **Seeding:** NUM_LP=4, start → four q_enq with data {0,0}, {1,0}, {2,0}, {3,0} on consecutive cycles, then RUN.
- **Full stall:** q_full held for 3 cycles during INIT → no q_enq in those cycles; seeding completes 3 cycles late.
- **Arbitration:** all four cores raise core_new_vld together → acks granted in order 0,1,2,3 on four consecutive cycles; no q_deq during those cycles.
- **GVT:** busy times {5,9}, q_head.time=7 → gvt=5 next cycle. After core with time 5 is acked, gvt=7.
- **End:** end_time=100 and gvt becomes 101 → done pulses once one cycle later, starved=0, then IDLE.
- **Starvation:** queue empties with no busy cores → done pulse with starved=1. Reset mid-RUN → all outputs at reset values and no done pulse.

Source files
------------

// File: rtl/pdes_pkg.sv
// Shared PHOLD definitions: dispatcher FSM states and the {lp, time} event layout
// used by pdes_dispatch, phold_core and prio_q.
package pdes_pkg;
    localparam int TIME_WID_DEF = 16;
    localparam int LP_WID_DEF   = 3;
    localparam int MSG_WID_DEF  = LP_WID_DEF + TIME_WID_DEF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_INIT = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Message layout: LP id in the upper bits, timestamp in the lower bits.
    typedef struct packed {
        logic [LP_WID_DEF-1:0]   lp;
        logic [TIME_WID_DEF-1:0] tm;
    } msg_t;
endpackage

// File: rtl/pdes_dispatch_rr_arb.sv
// Round-robin arbiter: one-hot grant starting the search at the pointer, which
// moves just past the granted requester whenever adv is asserted.
module rr_arb #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    input  logic          adv,
    output logic [N-1:0]  gnt,
    output logic          any,
    output logic [IW-1:0] idx
);
    logic [IW-1:0] ptr_q, ptr_d;
    logic          found;
    int            c;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        c     = 0;
        for (int k = 0; k < N; k++) begin
            c = (int'(ptr_q) + k) % N;
            if (!found && req[c]) begin
                found  = 1'b1;
                gnt[c] = 1'b1;
                idx    = IW'(c);
            end
        end
    end

    assign any   = |req;
    assign ptr_d = (idx == IW'(N - 1)) ? '0 : idx + IW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   ptr_q <= '0;
        else if (adv) ptr_q <= ptr_d;
    end
endmodule

// File: rtl/pdes_dispatch.sv
// PHOLD event dispatcher: seeds the queue, funnels core output into it, hands the
// earliest event to an idle core and tracks a monotonic GVT until end or starvation.
module pdes_dispatch
    import pdes_pkg::*;
#(
    parameter int NUM_CORE = 4,
    parameter int TIME_WID = TIME_WID_DEF,
    parameter int LP_WID   = LP_WID_DEF,
    parameter int NUM_LP   = 4,
    parameter int MSG_WID  = LP_WID + TIME_WID
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [TIME_WID-1:0]         end_time,
    output logic                        done,
    output logic                        starved,
    output logic [TIME_WID-1:0]         gvt,
    output logic [31:0]                 disp_cnt,
    output logic                        q_enq,
    output logic [MSG_WID-1:0]          q_enq_data,
    output logic                        q_deq,
    input  logic [MSG_WID-1:0]          q_head,
    input  logic                        q_empty,
    input  logic                        q_full,
    input  logic [NUM_CORE-1:0]         core_ready,
    output logic [NUM_CORE-1:0]         core_evt_vld,
    output logic [MSG_WID-1:0]          core_evt_data,
    input  logic [NUM_CORE-1:0]         core_new_vld,
    input  logic [NUM_CORE*MSG_WID-1:0] core_new_data,
    output logic [NUM_CORE-1:0]         core_new_ack
);
    localparam int CIW  = $clog2(NUM_CORE);
    localparam int SW   = LP_WID + 1;
    localparam int LOG  = $clog2(NUM_CORE + 1);
    localparam int LEAF = 1 << LOG;

    state_e                             state_q, state_d;
    logic [TIME_WID-1:0]                end_q, end_d, gvt_q, gvt_d;
    logic [31:0]                        disp_q, disp_d;
    logic                               starved_q, starved_d;
    logic [NUM_CORE-1:0]                busy_q, busy_d;
    logic [NUM_CORE-1:0][TIME_WID-1:0]  ctime_q, ctime_d;
    logic [SW-1:0]                      seed_q, seed_d;

    logic                rx_any, tx_any, rx_go, tx_go, seed_go, end_hit, act;
    logic [NUM_CORE-1:0] rx_gnt, tx_gnt;
    logic [CIW-1:0]      rx_idx, tx_idx;
    logic                c_vld;
    logic [TIME_WID-1:0] c_gvt;

    rr_arb #(.N(NUM_CORE), .IW(CIW)) u_rx_arb (
        .clk(clk), .rst_n(rst_n), .req(core_new_vld), .adv(rx_go),
        .gnt(rx_gnt), .any(rx_any), .idx(rx_idx)
    );

    rr_arb #(.N(NUM_CORE), .IW(CIW)) u_tx_arb (
        .clk(clk), .rst_n(rst_n), .req(core_ready & ~busy_q), .adv(tx_go),
        .gnt(tx_gnt), .any(tx_any), .idx(tx_idx)
    );

    // No new work is moved once GVT has passed the end time.
    assign end_hit = (state_q == ST_RUN) && (gvt_q > end_q);
    assign act     = (state_q == ST_RUN) && !end_hit;
    assign rx_go   = act && rx_any && !q_full;
    assign tx_go   = act && !rx_go && !q_empty && tx_any;
    assign seed_go = (state_q == ST_INIT) && !q_full;

    assign q_enq         = seed_go || rx_go;
    assign q_enq_data    = seed_go ? {seed_q[LP_WID-1:0], {TIME_WID{1'b0}}}
                                   : core_new_data[rx_idx*MSG_WID +: MSG_WID];
    assign q_deq         = tx_go;
    assign core_evt_vld  = tx_go ? tx_gnt : '0;
    assign core_evt_data = q_head;
    assign core_new_ack  = rx_go ? rx_gnt : '0;

    assign done     = (state_q == ST_DONE);
    assign starved  = starved_q;
    assign gvt      = gvt_q;
    assign disp_cnt = disp_q;

    // Min-reduction tree: leaves are the busy cores plus the queue head.
    for (genvar l = 0; l <= LOG; l++) begin : g_lvl
        localparam int W = LEAF >> l;
        logic [W-1:0]               v;
        logic [W-1:0][TIME_WID-1:0] t;
        if (l == 0) begin : g_leaf
            for (genvar i = 0; i < W; i++) begin : g_i
                if (i < NUM_CORE) begin : g_core
                    assign v[i] = busy_q[i];
                    assign t[i] = ctime_q[i];
                end else if (i == NUM_CORE) begin : g_q
                    assign v[i] = !q_empty;
                    assign t[i] = q_head[TIME_WID-1:0];
                end else begin : g_pad
                    assign v[i] = 1'b0;
                    assign t[i] = '0;
                end
            end
        end else begin : g_node
            for (genvar i = 0; i < W; i++) begin : g_i
                logic                lv, rv;
                logic [TIME_WID-1:0] lt, rt;
                assign lv   = g_lvl[l-1].v[2*i];
                assign rv   = g_lvl[l-1].v[2*i+1];
                assign lt   = g_lvl[l-1].t[2*i];
                assign rt   = g_lvl[l-1].t[2*i+1];
                assign v[i] = lv | rv;
                assign t[i] = (lv && (!rv || lt <= rt)) ? lt : rt;
            end
        end
    end

    assign c_vld = g_lvl[LOG].v[0];
    assign c_gvt = g_lvl[LOG].t[0];

    always_comb begin
        state_d   = state_q;
        end_d     = end_q;
        gvt_d     = gvt_q;
        disp_d    = disp_q;
        starved_d = starved_q;
        busy_d    = busy_q;
        ctime_d   = ctime_q;
        seed_d    = seed_q;
        case (state_q)
            ST_IDLE: if (start) begin
                state_d   = ST_INIT;
                end_d     = end_time;
                gvt_d     = '0;
                disp_d    = '0;
                starved_d = 1'b0;
                busy_d    = '0;
                seed_d    = '0;
            end
            ST_INIT: if (seed_go) begin
                seed_d = seed_q + SW'(1);
                if (seed_q == SW'(NUM_LP - 1)) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (rx_go) busy_d[rx_idx] = 1'b0;
                if (tx_go) begin
                    busy_d[tx_idx]  = 1'b1;
                    ctime_d[tx_idx] = q_head[TIME_WID-1:0];
                    if (disp_q != '1) disp_d = disp_q + 32'd1;
                end
                if (c_vld && c_gvt >= gvt_q) gvt_d = c_gvt;
                if (end_hit) begin
                    state_d = ST_DONE;
                end else if (q_empty && busy_q == '0 && core_new_vld == '0) begin
                    starved_d = 1'b1;
                    state_d   = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            end_q     <= '0;
            gvt_q     <= '0;
            disp_q    <= '0;
            starved_q <= 1'b0;
            busy_q    <= '0;
            ctime_q   <= '0;
            seed_q    <= '0;
        end else begin
            state_q   <= state_d;
            end_q     <= end_d;
            gvt_q     <= gvt_d;
            disp_q    <= disp_d;
            starved_q <= starved_d;
            busy_q    <= busy_d;
            ctime_q   <= ctime_d;
            seed_q    <= seed_d;
        end
    end
endmodule
